// File: rtl/booth_mul_issue_ctrl.sv
// booth_mul_issue_ctrl: FIFO-buffered issue front end for a 4-bit Booth multiplier
module booth_mul_issue_ctrl #(
  parameter int WIDTH   = 4,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 mul_str,
  output logic [WIDTH-1:0]     mul_multiplicand,
  output logic [WIDTH-1:0]     mul_multiplier,
  input  logic                 mul_valid,
  input  logic [2*WIDTH-1:0]   mul_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_result,
  output logic [WIDTH-1:0]     out_a,
  output logic [WIDTH-1:0]     out_b,
  output logic                 busy,
  output logic                 err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   mem_q [DEPTH];
  logic [2*WIDTH-1:0]   mem_d [DEPTH];
  logic [AW-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]        fill_q, fill_d;
  logic [TW-1:0]        tmr_q, tmr_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d, out_a_q, out_a_d, out_b_q, out_b_d;
  logic [2*WIDTH-1:0]   res_q, res_d;
  logic                 str_q, str_d, ov_q, ov_d, err_q, err_d, mul_valid_q;
  logic                 push, pop, done_edge;
  assign in_ready         = fill_q != CW'(DEPTH);
  assign busy             = state_q != IDLE || fill_q != '0;
  assign mul_str          = str_q;
  assign mul_multiplicand = a_q;
  assign mul_multiplier   = b_q;
  assign out_valid        = ov_q;
  assign out_result       = res_q;
  assign out_a            = out_a_q;
  assign out_b            = out_b_q;
  assign err              = err_q;
  always_comb begin
    push      = in_valid && in_ready;
    // The head is only consumed when the FSM is about to enter ISSUE.
    pop       = fill_q != '0 && (state_q == IDLE || (state_q == HOLD && out_ready));
    // A level left high from the previous product must not count as completion.
    done_edge = mul_valid && !mul_valid_q;
    mem_d = mem_q;
    if (push) mem_d[wr_q] = {in_a, in_b};
    wr_d       = push ? wr_q + 1'b1 : wr_q;
    rd_d       = pop ? rd_q + 1'b1 : rd_q;
    fill_d     = fill_q + CW'(push) - CW'(pop);
    {a_d, b_d} = pop ? mem_q[rd_q] : {a_q, b_q};
    state_d = state_q;
    tmr_d   = tmr_q;
    res_d   = res_q;
    out_a_d = out_a_q;
    out_b_d = out_b_q;
    ov_d    = ov_q;
    err_d   = err_q;
    case (state_q)
      IDLE:  if (pop) state_d = ISSUE;
      ISSUE: begin
        state_d = WAIT;
        tmr_d   = '0;
      end
      WAIT: begin
        if (done_edge) begin
          res_d   = mul_result;
          out_a_d = a_q;
          out_b_d = b_q;
          ov_d    = 1'b1;
          state_d = HOLD;
        end else if (tmr_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          ov_d    = 1'b0;
          state_d = pop ? ISSUE : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    str_d = state_d == ISSUE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_q       <= '{default: '0};
      wr_q        <= '0;
      rd_q        <= '0;
      fill_q      <= '0;
      tmr_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      res_q       <= '0;
      str_q       <= 1'b0;
      ov_q        <= 1'b0;
      err_q       <= 1'b0;
      mul_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      fill_q      <= fill_d;
      tmr_q       <= tmr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      res_q       <= res_d;
      str_q       <= str_d;
      ov_q        <= ov_d;
      err_q       <= err_d;
      mul_valid_q <= mul_valid;
    end
  end
endmodule
